image_load_unit: RTL

Front-end stage of the dithering accelerator. Accepts an interleaved R,G,B byte stream over a valid/ready handshake, converts each pixel to 8-bit grayscale luma, and writes it in raster order into the pixel buffer consumed by the Floyd-Steinberg error-diffusion unit. Signals frame completion so the dithering loop can start.

---
 rtl/image_load_if.sv | 27 ++
 rtl/image_load_unit.sv | 90 +++++++++
 2 files changed

// File: rtl/image_load_if.sv
// Stream-in / pixel-buffer-out bundle of the image load unit.
// slave = the load unit, master = the byte source / buffer observer.
interface image_load_if #(
    parameter int RGB_SIZE   = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [RGB_SIZE-1:0]   in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [RGB_SIZE-1:0]   wr_data;
    logic                  busy;
    logic                  frame_done;
    logic [ADDR_WIDTH-1:0] pixel_count;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, frame_done, pixel_count
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, frame_done, pixel_count
    );
endinterface

// File: rtl/image_load_unit.sv
// Converts an interleaved R,G,B byte stream to 8-bit luma and writes it in
// raster order into the pixel buffer; pulses frame_done after the last pixel.
module image_load_unit #(
    parameter int IMAGEX     = 64,
    parameter int IMAGEY     = 64,
    parameter int IMAGE_SIZE = IMAGEX * IMAGEY,
    parameter int RGB_SIZE   = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    image_load_if.slave bus
);
    localparam int ACC_W = 2 * RGB_SIZE;
    localparam logic [ACC_W-1:0] W_R = ACC_W'(77);
    localparam logic [ACC_W-1:0] W_G = ACC_W'(150);
    localparam logic [ACC_W-1:0] W_B = ACC_W'(29);
    localparam logic [ADDR_WIDTH:0] LAST_PIX = (ADDR_WIDTH + 1)'(IMAGE_SIZE - 1);
    localparam logic [ADDR_WIDTH:0] PORT_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    // One bit wider than the address so the count can reach IMAGE_SIZE.
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    in_ext;

    assign in_ext = ACC_W'(bus.in_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = GET_R;
                    cnt_d   = '0;
                end
            end
            GET_R: begin
                if (bus.in_valid) begin
                    acc_d   = in_ext * W_R;
                    state_d = GET_G;
                end
            end
            GET_G: begin
                if (bus.in_valid) begin
                    acc_d   = acc_q + in_ext * W_G;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.in_valid) begin
                    acc_d   = acc_q + in_ext * W_B;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_PIX) ? DONE : GET_R;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode registered state only.
    assign bus.in_ready   = (state_q == GET_R) || (state_q == GET_G) || (state_q == GET_B);
    assign bus.wr_en      = (state_q == WRITE);
    assign bus.wr_addr    = cnt_q[ADDR_WIDTH-1:0];
    assign bus.wr_data    = acc_q[ACC_W-1:RGB_SIZE];
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = (state_q == DONE);
    // When IMAGE_SIZE equals 2^ADDR_WIDTH the full count does not fit the port; clamp it.
    assign bus.pixel_count = (cnt_q > PORT_MAX) ? {ADDR_WIDTH{1'b1}} : cnt_q[ADDR_WIDTH-1:0];
endmodule
